// File: rtl/alu_result_display_if.sv
// Bundle between the ALU result and the display stage: the ALU drives answer,
// and the display stage returns the segment, enable and busy outputs.
interface alu_result_display_if;
    logic [7:0] answer;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    modport master (
        output answer,
        input  seg,
        input  an,
        input  busy
    );

    modport slave (
        input  answer,
        output seg,
        output an,
        output busy
    );
endinterface

// File: rtl/alu_result_display.sv
// Converts the 8-bit ALU answer to BCD with an iterative double-dabble engine and
// scans it onto a 4-digit common-anode 7-segment display with leading-zero blanking.
module alu_result_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_display_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

    state_t                  state_reg;
    logic [19:0]             shreg_reg;
    logic [2:0]              bit_cnt_reg;
    logic [7:0]              cap_reg;
    logic [7:0]              last_val_reg;
    logic                    force_reg;
    logic [3:0]              hund_reg;
    logic [3:0]              tens_reg;
    logic [3:0]              ones_reg;
    logic [REFRESH_BITS-1:0] scan_cnt_reg;
    logic [6:0]              seg_reg;
    logic [3:0]              an_reg;
    logic                    busy_reg;

    logic [11:0]             bcd_adj;
    logic [1:0]              slot;
    logic [6:0]              seg_next;
    logic [3:0]              an_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_add3
        assign bcd_adj[gi*4 +: 4] = (shreg_reg[8 + gi*4 +: 4] >= 4'd5)
                                  ? shreg_reg[8 + gi*4 +: 4] + 4'd3
                                  : shreg_reg[8 + gi*4 +: 4];
    end

    assign slot = scan_cnt_reg[REFRESH_BITS-1 -: 2];

    // Enable and segments are chosen together so they always describe the same digit.
    always_comb begin
        seg_next = 7'h7F;
        an_next  = 4'hF;
        case (slot)
            2'd0: begin
                an_next  = 4'b1110;
                seg_next = seg_code(ones_reg);
            end
            2'd1: begin
                if (hund_reg != 4'd0 || tens_reg != 4'd0) begin
                    an_next  = 4'b1101;
                    seg_next = seg_code(tens_reg);
                end
            end
            2'd2: begin
                if (hund_reg != 4'd0) begin
                    an_next  = 4'b1011;
                    seg_next = seg_code(hund_reg);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            cap_reg      <= '0;
            last_val_reg <= '0;
            force_reg    <= 1'b1;
            hund_reg     <= '0;
            tens_reg     <= '0;
            ones_reg     <= '0;
            scan_cnt_reg <= '0;
            seg_reg      <= 7'h7F;
            an_reg       <= 4'hF;
            busy_reg     <= 1'b0;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + REFRESH_BITS'(1);
            seg_reg      <= seg_next;
            an_reg       <= an_next;
            case (state_reg)
                IDLE: begin
                    if (bus.answer != last_val_reg || force_reg) begin
                        cap_reg     <= bus.answer;
                        shreg_reg   <= {12'b0, bus.answer};
                        bit_cnt_reg <= '0;
                        state_reg   <= CONV;
                        busy_reg    <= 1'b1;
                    end
                end
                CONV: begin
                    shreg_reg   <= {bcd_adj[10:0], shreg_reg[7:0], 1'b0};
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_reg <= UPD;
                end
                UPD: begin
                    {hund_reg, tens_reg, ones_reg} <= shreg_reg[19:8];
                    last_val_reg <= cap_reg;
                    force_reg    <= 1'b0;
                    state_reg    <= IDLE;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.seg  = seg_reg;
    assign bus.an   = an_reg;
    assign bus.busy = busy_reg;
endmodule

// File: doc/alu_result_display.md
# alu_result_display

Downstream stage of the ALU top level. Consumes the 8-bit ALU `answer`, converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine, and drives a 4-digit, time-multiplexed, common-anode 7-segment display with leading-zero blanking. Conversion restarts automatically whenever the `answer` value changes, so no valid strobe is needed from the ALU.

## Interface
- `REFRESH_BITS`, default 16: width of the scan counter. Its top 2 bits select the digit slot. Simulation uses 4.
- `clk` input 1: system clock, the same clock as the ALU.
- `reset` input 1: synchronous, active-high.
- `answer` input 8: unsigned ALU result, connected directly to the ALU `answer` output.
- `seg` output 7: active-low segments `{g,f,e,d,c,b,a}`. Registered.
- `an` output 4: active-low digit enables. `an[0]` is the ones digit. Registered.
- `busy` output 1: high while a conversion is in progress (state ≠ IDLE). Registered.

## Operation
- FSM states: IDLE, CONV, UPD.
  - **IDLE:** if `answer != last_val` or `force == 1`, capture `answer` into `shreg = {12'b0, answer}`, clear the bit counter, and go to CONV. Otherwise stay in IDLE.
  - **CONV:** on each cycle, for every BCD nibble of `shreg[19:8]` that is ≥ 5, add 3 to it; then shift `shreg` left by 1. The bit counter increments. After the 8th shift, go to UPD.
  - **UPD:** load `{hund, tens, ones} <= shreg[19:8]`, `last_val <=` the captured value, and `force <= 0`. Return to IDLE.
- Changes on `answer` during CONV or UPD are ignored. The new value is detected in the IDLE cycle that follows. No value is ever lost if `answer` settles.
- Scan:
  - The `REFRESH_BITS`-wide counter free-runs and wraps.
  - Slot `cnt[MSB:MSB-1]`: 0 shows ones, 1 shows tens, 2 shows hundreds, 3 shows nothing.
  - Slot 3 always produces `an = 4'hF` and `seg = 7'h7F`.
- Blanking:
  - Hundreds is blank when `hund == 0`.
  - Tens is blank when `hund == 0` and `tens == 0`.
  - Ones is never blank.
  - A blank slot outputs `an = 4'hF` and `seg = 7'h7F`.
- Active-low segment codes for digits 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- BCD nibble values greater than 9 cannot occur. The decoder default is `7'h7F`.

## Timing
- Reset values:
  - State IDLE, `busy = 0`, `an = 4'hF`, `seg = 7'h7F`.
  - Scan counter 0, `hund`/`tens`/`ones` = 0, `last_val = 0`, `force = 1`.
- The first conversion after reset is therefore unconditional, including when `answer = 0`.
- Latency, with `answer` sampled at edge E0:
  - `busy` is high from E0 until E9. This is 9 cycles: 8 CONV cycles and 1 UPD cycle.
  - Digit registers update at E9.
  - The earliest new value can be sampled at E10, when the FSM is back in IDLE.
- Minimum re-conversion period: 10 cycles.
- `an` and `seg` are registered from the scan counter and digit registers. They lag the slot index by 1 cycle and are always mutually consistent: they never show one digit's segments with another digit's enable.
- The display keeps showing the previous value, glitch-free, throughout a conversion.
- Reset asserted mid-conversion aborts it: the FSM returns to IDLE and the outputs take their reset values on the next edge. The conversion restarts through `force` after reset deasserts.
- Simultaneous `reset` and an `answer` change: reset wins.

## Test plan
- **Reset then `answer = 0`:** after `reset`, expect `busy` high for 9 cycles. Then the ones slot shows `an = 4'b1110` with `seg = 7'h40`; the tens, hundreds and slot-3 slots show `an = 4'hF` with `seg = 7'h7F`.
- **`answer = 255`:** expect digits 2/5/5. Ones: `an = 1110`, `seg = 12`. Tens: `an = 1101`, `seg = 12`. Hundreds: `an = 1011`, `seg = 24`. Conversion completes exactly 9 cycles after the capture edge.
- **`answer = 7`, then `answer = 100`:**
  - For 7, hundreds and tens are blank and ones shows `seg = 78`.
  - For 100, hundreds shows `79`, tens shows `40` (not blanked, because hundreds ≠ 0), and ones shows `40`.
- **Change during conversion:** drive `answer = 42`, then `answer = 199` 3 cycles later. Expect the display to show 42 first. A second conversion must start on the first IDLE cycle and end with 1/9/9 displayed. `busy` must drop for exactly 1 cycle between the two conversions.
- **Reset mid-conversion:** start converting 128 and assert `reset` at cycle 4 of CONV. Expect outputs at reset values on the next edge. After release, with `answer = 128` held, expect a fresh conversion and a display of 1/2/8.
- **Steady `answer`:** hold `answer = 63` for 1000 cycles. Expect exactly one conversion. The scan must cycle through slots 0, 1, 2, 3 every 2^`REFRESH_BITS` cycles per full sweep, with slot 2 blank and an `an` one-hot-low pattern (or `4'hF`) in every cycle.
